// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (start + DATA_BITS + [parity] + stop) feeding a
// show-ahead receive FIFO with valid/ready output and one-cycle error pulses.
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state and check;
// without it parity_err is tied low and PARITY_ODD has no effect.
// rx_state exposes the receiver FSM state (IDLE=0, START=1, DATA=2,
// PARITY=3, STOP=4) for observation.
//
// Output handshake: a word transfers on every rising sys_clk edge where
// rx_valid && rx_ready; rx_valid never depends combinationally on rx_ready,
// and rx_data stays stable while rx_valid is high until that transfer.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          uart_rxd,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic [2:0]                    rx_state
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CW      = $clog2(BPS_CNT);
    localparam int BW      = $clog2(DATA_BITS + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_MID   = CW'(BPS_CNT / 2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BPS_CNT - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS);
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t                 state;
    logic [1:0]             sync_q;
    logic                   line;
    logic                   line_prev;
    logic [CW-1:0]          clk_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bad;

    logic                   start_det;
    logic                   mid;
    logic                   wrap;
    logic                   stop_mid;
    logic                   full;
    logic                   pop;
    logic                   push;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          rd_nxt;
    logic [AW:0]            count_nxt;
    logic                   head_new;

    assign line      = sync_q[1];
    assign start_det = line_prev & ~line;
    assign mid       = (clk_cnt == CNT_MID);
    assign wrap      = (clk_cnt == CNT_LAST);
    assign stop_mid  = (state == ST_STOP) && mid;
    assign full      = (rx_count == DEPTH_C);
    assign pop       = rx_valid & rx_ready;
    assign push      = stop_mid & line & ~par_bad & (~full | pop);
    assign rx_state  = state;

`ifndef UART_RX_PARITY_EN
    logic unused_cfg;
    assign unused_cfg = PAR_ODD;
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    // Two-flop synchroniser plus one history bit for falling-edge detection.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q    <= 2'b11;
            line_prev <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], uart_rxd};
            line_prev <= sync_q[1];
        end
    end

    // Receiver FSM: baud counting, mid-bit sampling and registered error pulses.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= stop_mid & ~line;
            overrun   <= stop_mid & line & ~par_bad & full & ~pop;
`ifdef UART_RX_PARITY_EN
            parity_err <= stop_mid & line & par_bad;
`endif
            clk_cnt <= wrap ? '0 : clk_cnt + CW'(1);
            case (state)
                ST_IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (start_det) state <= ST_START;
                end
                ST_START: begin
                    // A line back high at mid-bit was only a glitch.
                    if (mid && line) begin
                        state   <= ST_IDLE;
                        clk_cnt <= '0;
                    end else if (wrap) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (mid) begin
                        shreg   <= {line, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                    if (wrap && bit_cnt == BITS_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state <= ST_PARITY;
`else
                        state <= ST_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (mid) par_bad <= (^shreg) ^ line ^ PAR_ODD;
                    if (wrap) state <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    // Leave at mid stop bit so a following start edge is seen.
                    if (mid) begin
                        state   <= ST_IDLE;
                        clk_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Next occupancy, next read pointer, and whether the head becomes the pushed word.
    always_comb begin
        count_nxt = rx_count;
        if (push && !pop) count_nxt = rx_count + (AW+1)'(1);
        if (pop && !push) count_nxt = rx_count - (AW+1)'(1);
        rd_nxt   = pop ? rd_ptr + AW'(1) : rd_ptr;
        head_new = (rx_count == '0) || (pop && rx_count == (AW+1)'(1));
    end

    // FIFO storage write port.
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    // FIFO pointers, occupancy and registered show-ahead head word.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr   <= rd_nxt;
            rx_count <= count_nxt;
            rx_valid <= (count_nxt != '0);
            if (count_nxt != '0) begin
                rx_data <= head_new ? shreg : mem[rd_nxt];
            end
        end
    end

endmodule
